// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, ALU operations,
// sequencer states and the bundled control-output word.
package cpu_pkg;

  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LS   = 4'b0010;
  localparam logic [3:0] OP_SS   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_R    = 4'b0110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b01;
  localparam logic [1:0] ALUOP_CMP   = 2'b10;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    ADDR   = 3'd3,
    MEM_RD = 3'd4,
    MEM_WR = 3'd5,
    WB     = 3'd6,
    BRANCH = 3'd7
  } seq_state_t;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       irWrite;
    logic       pcWrite;
    logic       pcSrc;
    logic       regDst;
    logic       aluSrc;
    logic       memToReg;
    logic       regWrite;
    logic [1:0] aluOp;
    logic       illegal;
  } ctrl_t;

  function automatic logic isLegalOp(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ADDI, OP_LS, OP_SS, OP_BEQ, OP_R: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/seq_output_decode.sv
// Purely combinational control-word decode for the sequencer: Moore outputs per
// state, qualified by the memory handshake, the branch zero flag and reset.
module seq_output_decode
  import cpu_pkg::*;
(
  input  seq_state_t state,
  input  logic [3:0] opQ,
  input  logic       run,
  input  logic       memReady,
  input  logic       zero,
  input  logic       reset,
  output ctrl_t      ctrl
);

  // Control outputs from current state; reset forces a quiet bus so an aborted request drops at once.
  always_comb begin
    ctrl = '0;
    if (reset) begin
      ctrl = '0;
    end else begin
      case (state)
        FETCH: begin
          if (run) begin
            ctrl.memRead = 1'b1;
            ctrl.iOrD    = 1'b0;
            if (memReady) begin
              ctrl.irWrite = 1'b1;
              ctrl.pcWrite = 1'b1;
              ctrl.pcSrc   = 1'b0;
            end else begin
              ctrl.irWrite = 1'b0;
            end
          end else begin
            ctrl = '0;
          end
        end
        DECODE: begin
          ctrl.illegal = ~isLegalOp(opQ);
        end
        EXEC: begin
          if (opQ == OP_R) begin
            ctrl.aluSrc = 1'b0;
            ctrl.aluOp  = ALUOP_FUNCT;
          end else if (opQ == OP_ADDI) begin
            ctrl.aluSrc = 1'b1;
            ctrl.aluOp  = ALUOP_ADD;
          end else begin
            ctrl.aluOp  = ALUOP_ADD;
          end
        end
        ADDR: begin
          ctrl.aluSrc = 1'b1;
          ctrl.aluOp  = ALUOP_ADD;
        end
        MEM_RD: begin
          ctrl.memRead = 1'b1;
          ctrl.iOrD    = 1'b1;
        end
        MEM_WR: begin
          ctrl.memWrite = 1'b1;
          ctrl.iOrD     = 1'b1;
        end
        WB: begin
          ctrl.regWrite = 1'b1;
          ctrl.regDst   = (opQ == OP_R);
          ctrl.memToReg = (opQ == OP_LS);
        end
        BRANCH: begin
          ctrl.aluSrc  = 1'b0;
          ctrl.aluOp   = ALUOP_CMP;
          ctrl.pcSrc   = 1'b1;
          ctrl.pcWrite = zero;
        end
        default: begin
          ctrl = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back over one shared request/ready memory port.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [2:0] state
);

  seq_state_t stateR;
  seq_state_t nextStateS;
  logic [3:0] opQR;
  ctrl_t      ctrlS;

  seq_output_decode uDecode (
    .state    (stateR),
    .opQ      (opQR),
    .run      (run),
    .memReady (mem_ready),
    .zero     (zero),
    .reset    (reset),
    .ctrl     (ctrlS)
  );

  // Next-state selection; decode and later states look only at the latched opcode.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      FETCH: begin
        if (run && mem_ready) begin
          nextStateS = DECODE;
        end else begin
          nextStateS = FETCH;
        end
      end
      DECODE: begin
        case (opQR)
          OP_R, OP_ADDI: nextStateS = EXEC;
          OP_LS, OP_SS:  nextStateS = ADDR;
          OP_BEQ:        nextStateS = BRANCH;
          default:       nextStateS = FETCH;
        endcase
      end
      EXEC: begin
        nextStateS = WB;
      end
      ADDR: begin
        if (opQR == OP_LS) begin
          nextStateS = MEM_RD;
        end else if (opQR == OP_SS) begin
          nextStateS = MEM_WR;
        end else begin
          nextStateS = FETCH;
        end
      end
      MEM_RD: begin
        if (mem_ready) begin
          nextStateS = WB;
        end else begin
          nextStateS = MEM_RD;
        end
      end
      MEM_WR: begin
        if (mem_ready) begin
          nextStateS = FETCH;
        end else begin
          nextStateS = MEM_WR;
        end
      end
      WB:      nextStateS = FETCH;
      BRANCH:  nextStateS = FETCH;
      default: nextStateS = FETCH;
    endcase
  end

  // State register and opcode latch, loaded together with the instruction register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR <= FETCH;
      opQR   <= 4'b0000;
    end else begin
      stateR <= nextStateS;
      if (ctrlS.irWrite) begin
        opQR <= opcode;
      end
    end
  end

  assign mem_read   = ctrlS.memRead;
  assign mem_write  = ctrlS.memWrite;
  assign i_or_d     = ctrlS.iOrD;
  assign ir_write   = ctrlS.irWrite;
  assign pc_write   = ctrlS.pcWrite;
  assign pc_src     = ctrlS.pcSrc;
  assign reg_dst    = ctrlS.regDst;
  assign alu_src    = ctrlS.aluSrc;
  assign mem_to_reg = ctrlS.memToReg;
  assign reg_write  = ctrlS.regWrite;
  assign alu_op     = ctrlS.aluOp;
  assign illegal    = ctrlS.illegal;
  assign state      = stateR;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 24-bit CPU. It replaces single-cycle decode with a state machine that steps each instruction through fetch, decode, execute, memory and write-back, sharing one memory port between instruction and data accesses through a request/ready handshake. It sits between the instruction register/opcode field and the datapath muxes, register file, PC and memory port.

## Interface
Parameters:
- none. Opcode, ALU-op and state encodings come from the shared package.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- run  in  1  allow a new fetch to start; sampled in FETCH only
- opcode  in  4  bits [23:20] of the memory read data; valid when mem_ready is high in FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  address select: 0 = PC, 1 = ALU result
- ir_write  out  1  load the instruction register
- pc_write  out  1  load the PC
- pc_src  out  1  PC source: 0 = PC+1, 1 = branch target
- reg_dst, alu_src, mem_to_reg, reg_write  out  1 each  datapath controls
- alu_op  out  2  00 add, 01 R-format funct, 10 compare/subtract
- illegal  out  1  one-cycle pulse on an undefined opcode
- state  out  3  current state, for debug

## Operation
- Opcodes: ADDI 0001, LS 0010, SS 0011, BEQ 0100, R 0110. Every other value is illegal.
- Registered op_q captures opcode when FETCH completes (ir_write). Decode uses op_q only.
- States and encoding: FETCH 0, DECODE 1, EXEC 2, ADDR 3, MEM_RD 4, MEM_WR 5, WB 6, BRANCH 7.
- FETCH:
  - While run=1: mem_read=1, i_or_d=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - While run=0: all outputs 0, stay in FETCH.
- DECODE:
  - R or ADDI -> EXEC.
  - LS or SS -> ADDR.
  - BEQ -> BRANCH.
  - Any other opcode: illegal=1, go to FETCH, no architectural side effects.
- EXEC:
  - R: alu_src=0, alu_op=01.
  - ADDI: alu_src=1, alu_op=00.
  - Then go to WB.
- ADDR: alu_src=1, alu_op=00. LS -> MEM_RD; SS -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready go to WB.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready go to FETCH.
- WB: reg_write=1.
  - reg_dst=1 for R, otherwise 0.
  - mem_to_reg=1 for LS, otherwise 0.
  - Then go to FETCH.
- BRANCH: alu_src=0, alu_op=10, pc_src=1, pc_write=zero. Then go to FETCH.
- Every output not listed for a state is 0. No output is ever X; SS drives reg_write=0 and reg_dst=0.
- Outputs are combinational from state, op_q, mem_ready and zero (Moore plus handshake qualifiers).

## Timing
- Reset: state=FETCH, op_q=0000. With run=0 every output is 0. Reset mid-request drops mem_read/mem_write immediately, with no further PC or IR write.
- Handshake:
  - A request stays asserted, with a stable i_or_d, until the cycle mem_ready=1.
  - mem_ready is ignored when no request is active.
  - Zero-wait memory (mem_ready high in the request cycle) is legal.
- Cycle counts with zero-wait memory: R/ADDI 4, LS 5, SS 4, BEQ 3, illegal 2. Each wait cycle adds one cycle to FETCH, MEM_RD or MEM_WR.
- run falling mid-instruction does not stall; the instruction completes and the sequencer idles in FETCH.
- Back-to-back instructions: the cycle after WB, MEM_WR or BRANCH is FETCH, with no bubble.

## Structure
- Shared package cpu_pkg:
  - opcode constants OP_ADDI, OP_LS, OP_SS, OP_BEQ, OP_R
  - ALU-op constants ALUOP_ADD, ALUOP_FUNCT, ALUOP_CMP
  - state enum seq_state_t
- Sub-module seq_output_decode: purely combinational mapping from (state, op_q, mem_ready, zero) to all control outputs. cpu_sequencer holds the state register, op_q and next-state logic.

## Test plan
- Reset with run=0, then release: state=0 and all outputs 0 for 5 cycles. run=1: mem_read=1, i_or_d=0 the next cycle.
- ADDI with zero-wait memory: states 0,1,2,6,0. EXEC has alu_src=1, alu_op=00. WB has reg_write=1, reg_dst=0, mem_to_reg=0.
- LS with mem_ready delayed 3 cycles in MEM_RD: mem_read and i_or_d=1 held for 4 cycles. WB has mem_to_reg=1. Total 8 cycles.
- BEQ with zero=1, then BEQ with zero=0: BRANCH has pc_src=1 in both. pc_write=1 only in the first.
- Opcode 1111: illegal pulses one cycle in DECODE, then back to FETCH. reg_write, mem_write and pc_write stay 0 after fetch.
- SS with reset asserted during MEM_WR wait: mem_write drops in the same cycle, state=0, and the next fetch proceeds normally.
